// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timekeeping engine: prescaled BCD hh:mm:ss.cc counter with
// start/stop, split (frozen display) and clear, feeding the digit multiplexer.
module stopwatch_bcd_core #(
   parameter int CENT_DIV = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       split,
   input  logic       clear,
   output logic [3:0] cent_0,
   output logic [3:0] cent_1,
   output logic [3:0] sec_0,
   output logic [3:0] sec_1,
   output logic [3:0] min_0,
   output logic [3:0] min_1,
   output logic [3:0] hr_0,
   output logic [3:0] hr_1,
   output logic       splitcheck,
   output logic       running,
   output logic       wrap
);

   localparam int PW = $clog2(CENT_DIV);
   localparam logic [PW-1:0] PMAX = PW'(CENT_DIV - 1);
   // Digit index 0 = cent_0 ... 7 = hr_1; per-digit roll-over value.
   localparam logic [7:0][3:0] DMAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

   typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    presc;
   logic [7:0][3:0]  cnt, cnt_nxt, snap;
   logic             split_active;
   logic             tick, carry;
   logic             do_clear, split_set, split_clr;

   assign tick = (state == RUNNING) && (presc == PMAX);

   // Ripple carry across all eight digits in one cycle; carry out marks the wrap.
   always_comb begin
      cnt_nxt = cnt;
      carry   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (carry) begin
            if (cnt[i] >= DMAX[i]) begin
               cnt_nxt[i] = 4'd0;
            end else begin
               cnt_nxt[i] = cnt[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Priority clear > start_stop > split, considering only inputs legal in the state.
   always_comb begin
      state_nxt = state;
      do_clear  = 1'b0;
      split_set = 1'b0;
      split_clr = 1'b0;
      case (state)
         IDLE: begin
            if (start_stop) state_nxt = RUNNING;
         end
         RUNNING: begin
            if (start_stop) state_nxt = STOPPED;
            else if (split) begin
               if (split_active) split_clr = 1'b1;
               else              split_set = 1'b1;
            end
         end
         STOPPED: begin
            if (clear) begin
               state_nxt = IDLE;
               do_clear  = 1'b1;
            end else if (start_stop) state_nxt = RUNNING;
            else if (split)          split_clr = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc        <= '0;
         cnt          <= '0;
         snap         <= '0;
         split_active <= 1'b0;
         wrap         <= 1'b0;
      end else begin
         if (do_clear) begin
            cnt   <= '0;
            presc <= '0;
         end else if (state == RUNNING) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) cnt <= cnt_nxt;
         end
         wrap <= tick & carry;
         // Snapshot samples the pre-increment count even on a tick edge.
         if (split_set) begin
            snap         <= cnt;
            split_active <= 1'b1;
         end else if (split_clr || do_clear) begin
            split_active <= 1'b0;
         end
      end
   end

   logic [7:0][3:0] disp;
   assign disp       = split_active ? snap : cnt;
   assign cent_0     = disp[0];
   assign cent_1     = disp[1];
   assign sec_0      = disp[2];
   assign sec_1      = disp[3];
   assign min_0      = disp[4];
   assign min_1      = disp[5];
   assign hr_0       = disp[6];
   assign hr_1       = disp[7];
   assign splitcheck = split_active;
   assign running    = (state == RUNNING);

endmodule
